// File: rtl/axi2per_pkg.sv
// Shared types and burst encodings for the AXI-to-peripheral request scheduler.
package axi2per_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } sched_state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
    } burst_cfg_t;

endpackage

// File: rtl/axi2per_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP AXI bursts.
module axi2per_addr_gen
    import axi2per_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [7:0]            len_i,
    input  logic [2:0]            size_i,
    input  logic [1:0]            burst_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] region;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH:0]   incr_w;
    logic [ADDR_WIDTH:0]   upper;
    logic                  wrap_ok;

    always_comb begin
        step    = ADDR_WIDTH'(1) << size_i;
        region  = step * (ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1));
        base    = addr_i & ~(region - ADDR_WIDTH'(1));
        // one extra bit so a region at the top of the address space still compares correctly
        incr_w  = {1'b0, addr_i} + {1'b0, step};
        upper   = {1'b0, base} + {1'b0, region};
        wrap_ok = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);

        next_addr_o = incr_w[ADDR_WIDTH-1:0];
        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_INCR:  next_addr_o = incr_w[ADDR_WIDTH-1:0];
            BURST_WRAP:  if (wrap_ok && (incr_w >= upper)) next_addr_o = base;
            default:     next_addr_o = incr_w[ADDR_WIDTH-1:0];
        endcase
    end

endmodule

// File: rtl/axi2per_req_sched.sv
// Read/write burst scheduler feeding single-beat peripheral requests.
// Define AXI2PER_SCHED_READ_PRIO_EN for fixed read priority instead of round-robin.
module axi2per_req_sched
    import axi2per_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    ar_valid_i,
    output logic                    ar_ready_o,
    input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
    input  logic [7:0]              ar_len_i,
    input  logic [2:0]              ar_size_i,
    input  logic [1:0]              ar_burst_i,
    input  logic [ID_WIDTH-1:0]     ar_id_i,

    input  logic                    aw_valid_i,
    output logic                    aw_ready_o,
    input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
    input  logic [7:0]              aw_len_i,
    input  logic [2:0]              aw_size_i,
    input  logic [1:0]              aw_burst_i,
    input  logic [ID_WIDTH-1:0]     aw_id_i,

    input  logic                    w_valid_i,
    output logic                    w_ready_o,
    input  logic [DATA_WIDTH-1:0]   w_data_i,
    input  logic [DATA_WIDTH/8-1:0] w_strb_i,
    input  logic                    w_last_i,

    output logic                    per_req_o,
    input  logic                    per_gnt_i,
    output logic [ADDR_WIDTH-1:0]   per_add_o,
    output logic                    per_we_o,
    output logic [DATA_WIDTH-1:0]   per_wdata_o,
    output logic [DATA_WIDTH/8-1:0] per_be_o,

    output logic                    trans_valid_o,
    input  logic                    trans_ready_i,
    output logic [ID_WIDTH-1:0]     trans_id_o,
    output logic                    trans_we_o,
    output logic                    trans_last_o,

    output logic                    err_wlast_o
);

    sched_state_t          state_q, state_d;
    sched_state_t          last_q, last_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    burst_cfg_t            cfg_q, cfg_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  rd_win;
    logic                  fire;
    logic                  cnt_zero;

    axi2per_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .addr_i      (addr_q),
        .len_i       (cfg_q.len),
        .size_i      (cfg_q.size),
        .burst_i     (cfg_q.burst),
        .next_addr_o (next_addr)
    );

    assign cnt_zero = (cnt_q == 8'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= WRITE;
            addr_q  <= '0;
            cfg_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            cfg_q   <= cfg_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
`ifdef AXI2PER_SCHED_READ_PRIO_EN
        rd_win = ar_valid_i;
`else
        // on a tie the direction that did not win last time goes first
        rd_win = ar_valid_i && (!aw_valid_i || (last_q == WRITE));
`endif
    end

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        addr_d        = addr_q;
        cfg_d         = cfg_q;
        id_d          = id_q;
        cnt_d         = cnt_q;
        fire          = 1'b0;
        ar_ready_o    = 1'b0;
        aw_ready_o    = 1'b0;
        w_ready_o     = 1'b0;
        per_req_o     = 1'b0;
        per_add_o     = '0;
        per_we_o      = 1'b0;
        per_wdata_o   = '0;
        per_be_o      = '0;
        trans_valid_o = 1'b0;
        trans_id_o    = '0;
        trans_we_o    = 1'b0;
        trans_last_o  = 1'b0;
        err_wlast_o   = 1'b0;

        case (state_q)
            IDLE: begin
                if (rd_win) begin
                    ar_ready_o = 1'b1;
                    addr_d     = ar_addr_i;
                    cfg_d      = '{len: ar_len_i, size: ar_size_i, burst: ar_burst_i};
                    id_d       = ar_id_i;
                    cnt_d      = ar_len_i;
                    state_d    = READ;
                end else if (aw_valid_i) begin
                    aw_ready_o = 1'b1;
                    addr_d     = aw_addr_i;
                    cfg_d      = '{len: aw_len_i, size: aw_size_i, burst: aw_burst_i};
                    id_d       = aw_id_i;
                    cnt_d      = aw_len_i;
                    state_d    = WRITE;
                end
            end
            READ, WRITE: begin
                per_add_o = addr_q;
                if (state_q == WRITE) begin
                    per_req_o   = w_valid_i && trans_ready_i;
                    per_we_o    = 1'b1;
                    per_wdata_o = w_data_i;
                    per_be_o    = w_strb_i;
                end else begin
                    per_req_o   = trans_ready_i;
                end
                fire = per_req_o && per_gnt_i;
                if (fire) begin
                    trans_valid_o = 1'b1;
                    trans_id_o    = id_q;
                    trans_we_o    = (state_q == WRITE);
                    trans_last_o  = cnt_zero;
                    w_ready_o     = (state_q == WRITE);
                    err_wlast_o   = (state_q == WRITE) && (w_last_i != cnt_zero);
                    addr_d        = next_addr;
                    cnt_d         = cnt_q - 8'd1;
                    if (cnt_zero) begin
                        last_d  = state_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi2per_req_sched.sv
// Directed bench for axi2per_req_sched: bursts, arbitration, stalls, W-last check, async reset.
module tb_axi2per_req_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ar_valid, ar_ready, aw_valid, aw_ready, w_valid, w_ready, w_last;
    logic [31:0] ar_addr, aw_addr, w_data, per_add, per_wdata;
    logic [7:0]  ar_len, aw_len;
    logic [2:0]  ar_size, aw_size;
    logic [1:0]  ar_burst, aw_burst;
    logic [3:0]  ar_id, aw_id, w_strb, per_be, trans_id;
    logic        per_req, per_gnt, per_we, trans_valid, trans_ready, trans_we, trans_last, err_wlast;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi2per_req_sched #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_addr_i(ar_addr), .ar_len_i(ar_len),
        .ar_size_i(ar_size), .ar_burst_i(ar_burst), .ar_id_i(ar_id),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_addr_i(aw_addr), .aw_len_i(aw_len),
        .aw_size_i(aw_size), .aw_burst_i(aw_burst), .aw_id_i(aw_id),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data), .w_strb_i(w_strb),
        .w_last_i(w_last),
        .per_req_o(per_req), .per_gnt_i(per_gnt), .per_add_o(per_add), .per_we_o(per_we),
        .per_wdata_o(per_wdata), .per_be_o(per_be),
        .trans_valid_o(trans_valid), .trans_ready_i(trans_ready), .trans_id_o(trans_id),
        .trans_we_o(trans_we), .trans_last_o(trans_last), .err_wlast_o(err_wlast)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] wrap_exp [4];

    initial begin
        wrap_exp = '{32'h38, 32'h3C, 32'h30, 32'h34};
        rst_n = 1'b0;
        ar_valid = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0; ar_id = 0;
        aw_valid = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0; aw_id = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0;
        per_gnt = 1; trans_ready = 1;

        // reset state
        #12;
        chk("rst_per_req", per_req, 0);
        chk("rst_ar_ready", ar_ready, 0);
        chk("rst_aw_ready", aw_ready, 0);
        chk("rst_trans_valid", trans_valid, 0);
        chk("rst_per_add", per_add, 0);
        chk("rst_err", err_wlast, 0);
        @(negedge clk); rst_n = 1'b1;

        // AR INCR 0x100 len 3 size 2
        @(negedge clk);
        ar_valid = 1; ar_addr = 32'h100; ar_len = 3; ar_size = 2; ar_burst = 2'b01; ar_id = 4'h5;
        #1;
        chk("t1_ar_ready", ar_ready, 1);
        chk("t1_aw_ready", aw_ready, 0);
        chk("t1_req_idle", per_req, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); ar_valid = 0; #1;
            chk("t1_req", per_req, 1);
            chk("t1_add", per_add, 32'h100 + 32'(4 * i));
            chk("t1_we", per_we, 0);
            chk("t1_tvalid", trans_valid, 1);
            chk("t1_tid", trans_id, 4'h5);
            chk("t1_twe", trans_we, 0);
            chk("t1_tlast", trans_last, (i == 3));
            chk("t1_ar_ready_busy", ar_ready, 0);
        end
        @(negedge clk); #1;
        chk("t1_done", per_req, 0);

        // AW WRAP 0x38 len 3 size 2
        @(negedge clk);
        aw_valid = 1; aw_addr = 32'h38; aw_len = 3; aw_size = 2; aw_burst = 2'b10; aw_id = 4'h9;
        #1;
        chk("t2_aw_ready", aw_ready, 1);
        chk("t2_ar_ready", ar_ready, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            aw_valid = 0; w_valid = 1; w_data = 32'hA0 + 32'(i); w_strb = 4'hF - 4'(i); w_last = (i == 3);
            #1;
            chk("t2_add", per_add, wrap_exp[i]);
            chk("t2_we", per_we, 1);
            chk("t2_wdata", per_wdata, 32'hA0 + 32'(i));
            chk("t2_be", per_be, 4'hF - 4'(i));
            chk("t2_w_ready", w_ready, 1);
            chk("t2_twe", trans_we, 1);
            chk("t2_tid", trans_id, 4'h9);
            chk("t2_tlast", trans_last, (i == 3));
            chk("t2_err", err_wlast, 0);
        end
        @(negedge clk); w_valid = 0; w_last = 0; #1;
        chk("t2_done", per_req, 0);

        // tie after a write -> read, then tie after a read -> write, then read again
        @(negedge clk);
        ar_valid = 1; ar_addr = 32'h200; ar_len = 0; ar_size = 2; ar_burst = 2'b01; ar_id = 4'h1;
        aw_valid = 1; aw_addr = 32'h300; aw_len = 0; aw_size = 2; aw_burst = 2'b01; aw_id = 4'h2;
        #1;
        chk("t3_tie1_ar", ar_ready, 1);
        chk("t3_tie1_aw", aw_ready, 0);
        @(negedge clk); #1;
        chk("t3_rd_add", per_add, 32'h200);
        chk("t3_rd_last", trans_last, 1);
        chk("t3_rd_aw_ready", aw_ready, 0);
        @(negedge clk); #1;
        chk("t3_tie2_aw", aw_ready, 1);
        chk("t3_tie2_ar", ar_ready, 0);
        @(negedge clk); aw_valid = 0; w_valid = 1; w_last = 1; w_data = 32'h55; w_strb = 4'h3; #1;
        chk("t3_wr_add", per_add, 32'h300);
        chk("t3_wr_id", trans_id, 4'h2);
        chk("t3_wr_err", err_wlast, 0);
        @(negedge clk); w_valid = 0; w_last = 0; aw_valid = 1; #1;
        chk("t3_tie3_ar", ar_ready, 1);
        chk("t3_tie3_aw", aw_ready, 0);
        @(negedge clk); ar_valid = 0; aw_valid = 0; #1;
        chk("t3_rd2_add", per_add, 32'h200);
        @(negedge clk); #1;
        chk("t3_done", per_req, 0);

        // FIXED len 2 with 3-cycle grant stall
        @(negedge clk);
        ar_valid = 1; ar_addr = 32'h400; ar_len = 2; ar_size = 2; ar_burst = 2'b00; ar_id = 4'h3;
        per_gnt = 0;
        #1;
        chk("t4_ar_ready", ar_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); ar_valid = 0; #1;
            chk("t4_stall_req", per_req, 1);
            chk("t4_stall_add", per_add, 32'h400);
            chk("t4_stall_tvalid", trans_valid, 0);
        end
        per_gnt = 1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("t4_add", per_add, 32'h400);
            chk("t4_tvalid", trans_valid, 1);
            chk("t4_tlast", trans_last, (i == 2));
        end
        @(negedge clk); #1;
        chk("t4_done", per_req, 0);

        // write len 2: wrong w_last on beat 1, trans_ready stall after it
        @(negedge clk);
        aw_valid = 1; aw_addr = 32'h500; aw_len = 2; aw_size = 2; aw_burst = 2'b01; aw_id = 4'h7;
        #1;
        chk("t5_aw_ready", aw_ready, 1);
        @(negedge clk); aw_valid = 0; w_valid = 1; w_last = 1; w_data = 32'h11; w_strb = 4'hF; #1;
        chk("t5_b1_add", per_add, 32'h500);
        chk("t5_b1_err", err_wlast, 1);
        chk("t5_b1_last", trans_last, 0);
        @(negedge clk); w_last = 0; w_data = 32'h22; trans_ready = 0; #1;
        chk("t5_stall_req", per_req, 0);
        chk("t5_stall_wready", w_ready, 0);
        chk("t5_stall_err", err_wlast, 0);
        @(negedge clk); #1;
        chk("t5_stall2_req", per_req, 0);
        @(negedge clk); trans_ready = 1; #1;
        chk("t5_b2_add", per_add, 32'h504);
        chk("t5_b2_wdata", per_wdata, 32'h22);
        chk("t5_b2_err", err_wlast, 0);
        @(negedge clk); w_last = 1; w_data = 32'h33; #1;
        chk("t5_b3_add", per_add, 32'h508);
        chk("t5_b3_last", trans_last, 1);
        chk("t5_b3_err", err_wlast, 0);
        @(negedge clk); w_valid = 0; w_last = 0; #1;
        chk("t5_done", per_req, 0);

        // async reset during 2nd beat of len-7 read
        @(negedge clk);
        ar_valid = 1; ar_addr = 32'h600; ar_len = 7; ar_size = 2; ar_burst = 2'b01; ar_id = 4'h4;
        #1;
        chk("t6_ar_ready", ar_ready, 1);
        @(negedge clk); ar_valid = 0; #1;
        chk("t6_b1_add", per_add, 32'h600);
        @(negedge clk); #1;
        chk("t6_b2_add", per_add, 32'h604);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req", per_req, 0);
        chk("t6_rst_add", per_add, 0);
        chk("t6_rst_tvalid", trans_valid, 0);
        chk("t6_rst_tlast", trans_last, 0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("t6_idle_req", per_req, 0);
        @(negedge clk);
        aw_valid = 1; aw_addr = 32'h700; aw_len = 0; aw_size = 2; aw_burst = 2'b01; aw_id = 4'hA;
        #1;
        chk("t6_aw_ready", aw_ready, 1);
        @(negedge clk); aw_valid = 0; w_valid = 1; w_last = 1; #1;
        chk("t6_wr_add", per_add, 32'h700);
        chk("t6_wr_we", per_we, 1);
        @(negedge clk); w_valid = 0; w_last = 0; #1;
        chk("t6_done", per_req, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
